// File: rtl/lib_pkt_source.sv
// Synthetic Bernoulli packet source for the write side of a downstream FIFO.
// An LFSR-versus-threshold decision offers packets; blocked offers queue as a backlog count.
module lib_pkt_source #(
  parameter int          ID_WIDTH   = 4,
  parameter int          SEQ_WIDTH  = 8,
  parameter int          TS_WIDTH   = 12,
  parameter int          RATE_WIDTH = 8,
  parameter int          BL_WIDTH   = 4,
  parameter int          SRC_ID     = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         i_enable,
  input  logic [RATE_WIDTH-1:0]                        i_rate,
  input  logic [15:0]                                  i_pkt_limit,
  input  logic                                         i_dest_mode,
  input  logic [ID_WIDTH-1:0]                          i_dest,
  input  logic                                         i_en,
  output logic [2*ID_WIDTH+SEQ_WIDTH+TS_WIDTH-1:0]     o_data,
  output logic                                         o_data_val,
  output logic                                         o_done,
  output logic [15:0]                                  o_sent_count,
  output logic [15:0]                                  o_drop_count
);

  localparam int W = 2*ID_WIDTH + SEQ_WIDTH + TS_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0]         SEED_EFF  = (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [15:0]         LFSR_MASK = 16'hB400;
  localparam logic [ID_WIDTH-1:0] SRC_FIELD = ID_WIDTH'(SRC_ID);
  localparam logic [BL_WIDTH-1:0] BL_MAX    = '1;

  logic [1:0]           state_q,   state_d;
  logic [15:0]          lfsr_q,    lfsr_d;
  logic [TS_WIDTH-1:0]  ts_q,      ts_d;
  logic [SEQ_WIDTH-1:0] seq_q,     seq_d;
  logic [BL_WIDTH-1:0]  backlog_q, backlog_d;
  logic [15:0]          loaded_q,  loaded_d;
  logic [W-1:0]         data_q,    data_d;
  logic                 val_q,     val_d;
  logic                 done_q,    done_d;
  logic [15:0]          sent_q,    sent_d;
  logic [15:0]          drop_q,    drop_d;

  logic                 limit_hit;
  logic                 run_go;
  logic                 gen;
  logic                 free;
  logic                 load;
  logic                 xfer;
  logic [15:0]          lfsr_next;
  logic [ID_WIDTH-1:0]  dest_sel;

  // Galois form, shifting right; the feedback mask is applied when bit 0 falls out.
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

  assign limit_hit = (i_pkt_limit != 16'd0) && (loaded_q >= i_pkt_limit);
  assign run_go    = (state_q == S_RUN) && i_enable && !limit_hit;
  assign gen       = run_go && ((&i_rate) || (lfsr_q[RATE_WIDTH-1:0] < i_rate));
  assign free      = ~val_q | i_en;
  assign load      = run_go && free && ((backlog_q != '0) || gen);
  assign xfer      = val_q & i_en;
  assign dest_sel  = i_dest_mode ? lfsr_q[15 -: ID_WIDTH] : i_dest;

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path can infer a latch.
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    ts_d      = ts_q + TS_WIDTH'(1);
    seq_d     = seq_q;
    backlog_d = backlog_q;
    loaded_d  = loaded_q;
    data_d    = data_q;
    val_d     = val_q;
    sent_d    = sent_q;
    drop_d    = drop_q;

    if (xfer) begin
      val_d = 1'b0;
      if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d   = S_RUN;
          sent_d    = '0;
          drop_d    = '0;
          seq_d     = '0;
          backlog_d = '0;
          loaded_d  = '0;
        end
      end

      S_RUN: begin
        lfsr_d = lfsr_next;
        if (!run_go) begin
          // Leaving RUN: the held packet stays put, only the unsent backlog is discarded.
          state_d   = S_DRAIN;
          backlog_d = '0;
        end else begin
          if (load) begin
            data_d   = {dest_sel, SRC_FIELD, seq_q, ts_q};
            val_d    = 1'b1;
            seq_d    = seq_q + SEQ_WIDTH'(1);
            loaded_d = loaded_q + 16'd1;
          end
          if (gen && !load) begin
            if (backlog_q == BL_MAX) begin
              if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end else begin
              backlog_d = backlog_q + BL_WIDTH'(1);
            end
          end else if (!gen && load) begin
            backlog_d = backlog_q - BL_WIDTH'(1);
          end
        end
      end

      S_DRAIN: begin
        if (!val_q) state_d = S_DONE;
      end

      S_DONE: begin
        if (!i_enable) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      ts_q      <= '0;
      seq_q     <= '0;
      backlog_q <= '0;
      loaded_q  <= '0;
      data_q    <= '0;
      val_q     <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ts_q      <= ts_d;
      seq_q     <= seq_d;
      backlog_q <= backlog_d;
      loaded_q  <= loaded_d;
      data_q    <= data_d;
      val_q     <= val_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
      drop_q    <= drop_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_val   = val_q;
  assign o_done       = done_q;
  assign o_sent_count = sent_q;
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_lib_pkt_source.sv
// Directed bench for lib_pkt_source: full rate, backpressure, zero rate, abort,
// rate statistics and async reset with LFSR reproduction.
module tb_lib_pkt_source;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [7:0]  i_rate = '0;
  logic [15:0] i_pkt_limit = '0;
  logic        i_dest_mode = 1'b0;
  logic [3:0]  i_dest = '0;
  logic        i_en = 1'b0;
  logic [27:0] o_data;
  logic        o_data_val;
  logic        o_done;
  logic [15:0] o_sent_count;
  logic [15:0] o_drop_count;

  int checks = 0;
  int errors = 0;
  int unsigned tb_cycle;

  lib_pkt_source dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .i_rate       (i_rate),
    .i_pkt_limit  (i_pkt_limit),
    .i_dest_mode  (i_dest_mode),
    .i_dest       (i_dest),
    .i_en         (i_en),
    .o_data       (o_data),
    .o_data_val   (o_data_val),
    .o_done       (o_done),
    .o_sent_count (o_sent_count),
    .o_drop_count (o_drop_count)
  );

  always #5 clk = ~clk;

  // Mirrors the free-running timestamp: counts every clock since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cycle <= 0;
    else          tb_cycle <= tb_cycle + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [27:0] pkt(input logic [3:0] d, input logic [7:0] s, input logic [11:0] t);
    return {d, 4'h0, s, t};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  logic [11:0] ts0;
  logic [15:0] lm;
  logic [7:0]  seq_m;
  logic        exp_val;
  logic [27:0] exp_data;
  logic        g;
  int          vals;
  int          total;
  int          dest_cnt[16];

  initial begin
    // Reset state
    #12;
    check("rst_val",  o_data_val,   0);
    check("rst_data", o_data,       0);
    check("rst_done", o_done,       0);
    check("rst_sent", o_sent_count, 0);
    check("rst_drop", o_drop_count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full rate, limit 10
    i_rate = 8'hFF; i_pkt_limit = 16'd10; i_en = 1'b1; i_dest_mode = 1'b0; i_dest = 4'd3;
    i_enable = 1'b1;
    step();
    ts0 = tb_cycle[11:0];
    check("full_c0_val", o_data_val, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("full_val",  o_data_val, 1);
      check("full_data", o_data, pkt(4'd3, 8'(k), ts0 + 12'(k)));
    end
    step();
    check("full_end_val",  o_data_val,   0);
    check("full_end_done", o_done,       0);
    check("full_sent",     o_sent_count, 10);
    step();
    check("full_done", o_done, 1);
    i_enable = 1'b0;
    step();
    check("full_idle_done", o_done, 0);

    // Backpressure: 20 stalled cycles, limit 16
    i_en = 1'b0; i_pkt_limit = 16'd16;
    i_enable = 1'b1;
    step();
    ts0 = tb_cycle[11:0];
    repeat (10) step();
    check("bp_hold_mid", o_data, pkt(4'd3, 8'd0, ts0));
    repeat (10) step();
    check("bp_drop",      o_drop_count, 4);
    check("bp_sent0",     o_sent_count, 0);
    check("bp_hold_data", o_data, pkt(4'd3, 8'd0, ts0));
    i_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("bp_val",  o_data_val, 1);
      check("bp_data", o_data, pkt(4'd3, 8'(k), (k == 0) ? ts0 : ts0 + 12'(19 + k)));
      step();
    end
    check("bp_end_val",  o_data_val, 0);
    check("bp_end_done", o_done,     0);
    step();
    check("bp_done",       o_done,       1);
    check("bp_sent",       o_sent_count, 16);
    check("bp_drop_final", o_drop_count, 4);
    i_enable = 1'b0;
    step();

    // Zero rate for 100 cycles
    i_rate = 8'h00; i_pkt_limit = 16'd0; i_en = 1'b1;
    i_enable = 1'b1;
    step();
    vals = 0;
    repeat (100) begin
      if (o_data_val) vals++;
      step();
    end
    check("zero_vals", vals, 0);
    check("zero_sent", o_sent_count, 0);
    i_enable = 1'b0;
    step();
    check("zero_drain_done", o_done, 0);
    step();
    check("zero_done", o_done, 1);
    step();
    check("zero_idle", o_done, 0);

    // Abort while the output is blocked
    i_rate = 8'hFF; i_en = 1'b0; i_dest = 4'd5;
    i_enable = 1'b1;
    step();
    ts0 = tb_cycle[11:0];
    repeat (5) step();
    check("abort_val",  o_data_val, 1);
    check("abort_data", o_data, pkt(4'd5, 8'd0, ts0));
    i_enable = 1'b0;
    repeat (2) begin
      step();
      check("abort_hold_val",  o_data_val, 1);
      check("abort_hold_data", o_data, pkt(4'd5, 8'd0, ts0));
      check("abort_hold_done", o_done, 0);
    end
    i_en = 1'b1;
    step();
    check("abort_xfer_val",  o_data_val,   0);
    check("abort_xfer_done", o_done,       0);
    check("abort_sent",      o_sent_count, 1);
    step();
    check("abort_done", o_done,       1);
    check("abort_drop", o_drop_count, 0);
    vals = 0;
    repeat (3) begin
      if (o_data_val) vals++;
      step();
    end
    check("abort_no_backlog", vals, 0);

    // Rate statistics: rate 64, random destinations
    i_rate = 8'd64; i_pkt_limit = 16'd0; i_en = 1'b1; i_dest_mode = 1'b1;
    for (int d = 0; d < 16; d++) dest_cnt[d] = 0;
    total = 0;
    i_enable = 1'b1;
    step();
    for (int i = 0; i <= 65536; i++) begin
      if (o_data_val) begin
        total++;
        dest_cnt[o_data[27:24]]++;
      end
      if (i == 65536) i_enable = 1'b0;
      step();
    end
    step();
    check("rate_done", o_done, 1);
    check("rate_sent_range", 32'((o_sent_count >= 16'd16056) && (o_sent_count <= 16'd16712)), 1);
    check("rate_seen_range", 32'((total >= 16056) && (total <= 16712)), 1);
    for (int d = 0; d < 16; d++)
      check($sformatf("rate_dest%0d_range", d), 32'((dest_cnt[d] >= 922) && (dest_cnt[d] <= 1126)), 1);
    step();

    // Async reset during RUN with a pending packet
    i_rate = 8'hFF; i_dest_mode = 1'b0; i_dest = 4'd7; i_en = 1'b1;
    i_enable = 1'b1;
    step();
    repeat (5) step();
    check("ar_sent_pre", o_sent_count, 4);
    i_en = 1'b0;
    repeat (20) step();
    check("ar_drop_pre", o_drop_count, 5);
    check("ar_val_pre",  o_data_val,   1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_val",  o_data_val,   0);
    check("ar_data", o_data,       0);
    check("ar_sent", o_sent_count, 0);
    check("ar_drop", o_drop_count, 0);
    check("ar_done", o_done,       0);
    i_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // New run: LFSR sequence reproduced from the seed, seq restarts at 0
    i_rate = 8'd128; i_dest_mode = 1'b1; i_en = 1'b1;
    i_enable = 1'b1;
    step();
    lm = 16'hACE1; seq_m = 8'd0; exp_val = 1'b0; exp_data = '0;
    for (int k = 0; k < 24; k++) begin
      check("seed_val", o_data_val, exp_val);
      if (exp_val) check("seed_data", o_data, exp_data);
      g = (lm[7:0] < 8'd128);
      if (g) begin
        exp_data = pkt(lm[15:12], seq_m, tb_cycle[11:0]);
        seq_m++;
      end
      exp_val = g;
      lm = lfsr_adv(lm);
      step();
    end
    i_enable = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
